// File: rtl/nway_reg_mux.sv
// nway_reg_mux: registered INPUTS-way operand select behind a valid/ready output register.
// Define NWAY_MUX_SKID_EN to add a skid register so in_ready carries no combinational path from out_ready.
module nway_reg_mux #(
  parameter int WIDTH = 32,
  parameter int INPUTS = 4,
  localparam int SEL_W = INPUTS > 1 ? $clog2(INPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUTS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [15:0]             xfer_count
);
  logic [WIDTH-1:0] word;
  logic bad, accept, xfer;
  // An out-of-range select matches no channel and leaves the word at zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < INPUTS; k++) if (sel == SEL_W'(k)) word = in_bus[k*WIDTH +: WIDTH];
  end
  assign bad = 32'(sel) >= INPUTS;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
`ifdef NWAY_MUX_SKID_EN
  logic [WIDTH-1:0] s_data;
  logic s_valid;
  assign in_ready = !s_valid;
  always_ff @(posedge clk)
    if (reset) begin
      s_valid <= 1'b0;
      s_data <= '0;
    end else if (accept && out_valid && !out_ready) begin
      s_data <= word;
      s_valid <= 1'b1;
    end else if (!accept && out_ready) s_valid <= 1'b0;
  // S only fills while M is stalled, so draining S always refills M.
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (accept && (!out_valid || out_ready)) begin
      out_data <= word;
      out_valid <= 1'b1;
    end else if (!accept && out_ready) begin
      if (s_valid) out_data <= s_data;
      else out_valid <= 1'b0;
    end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      out_data <= word;
      out_valid <= 1'b1;
    end else if (out_ready) out_valid <= 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      sel_err <= 1'b0;
      xfer_count <= '0;
    end else begin
      sel_err <= sel_err || (accept && bad);
      xfer_count <= xfer_count + 16'(xfer);
    end
endmodule

// File: tb/tb_nway_reg_mux.sv
// tb_nway_reg_mux: randomized scoreboard bench for nway_reg_mux (INPUTS=3 so an out-of-range select exists).
module tb_nway_reg_mux;
  localparam int W = 32;
  localparam int N = 3;
  logic clk = 0, reset = 1;
  logic [W-1:0] ch [N];
  logic [N*W-1:0] in_bus;
  logic [1:0] sel = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, sel_err;
  logic [W-1:0] out_data;
  logic [15:0] xfer_count;
  int checks = 0, fails = 0;
  logic [W-1:0] sb [$];
  logic [15:0] exp_cnt = 0;
  logic exp_err = 0, err_pend = 0, held = 0, rnd_run = 0;
  logic [W-1:0] last_data;

  nway_reg_mux #(.WIDTH(W), .INPUTS(N)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;
  always_comb in_bus = {ch[2], ch[1], ch[0]};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: an accepted request yields its channel value, or zero (and a sticky error) when sel >= N.
  always @(negedge clk)
    if (!reset && in_valid && in_ready) begin
      sb.push_back(sel < N ? ch[sel] : '0);
      if (sel >= N) err_pend = 1;
    end

  always @(posedge clk)
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
      exp_err = 0;
      err_pend = 0;
      held = 0;
    end else begin
      if (err_pend) exp_err = 1;
      err_pend = 0;
    end

  always @(negedge clk)
    if (!reset) begin
      chk("xfer_count", 32'(xfer_count), 32'(exp_cnt));
      chk("sel_err", 32'(sel_err), 32'(exp_err));
      if (held) chk("hold_stable", out_data, last_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_word", 32'(sb.size()), 32'd1);
        else chk("data", out_data, sb.pop_front());
        exp_cnt++;
      end
      held = out_valid && !out_ready;
      last_data = out_data;
    end

  always @(posedge clk)
    if (rnd_run) begin
      #1;
      out_ready = 1'($urandom % 2);
    end

  // Leaves in_valid high; returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] s);
    bit ok = 0;
    in_valid = 1;
    sel = s;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int t = 0; t < 200 && (sb.size() != 0 || out_valid); t++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ch[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);

    ch[0] = 32'h02119027;
    ch[1] = 32'h02119020;
    out_ready = 1;
    send(0);
    chk("lat_word0", out_data, 32'h02119027);
    chk("lat_valid0", 32'(out_valid), 32'd1);
    send(1);
    chk("lat_word1", out_data, 32'h02119020);
    drain();
    chk("xfer_two", 32'(xfer_count), 32'd2);

    out_ready = 0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join_none
    ch[0] = 32'hAAAA0001;
    send(0);
`ifdef NWAY_MUX_SKID_EN
    chk("skid_ready_after_a", 32'(in_ready), 32'd1);
    ch[1] = 32'hBBBB0002;
    send(1);
    chk("skid_ready_after_b", 32'(in_ready), 32'd0);
    ch[2] = 32'hCCCC0003;
    sel = 2;
    @(negedge clk);
    chk("skid_c_stalled", 32'(in_ready), 32'd0);
    send(2);
`else
    chk("full_not_ready", 32'(in_ready), 32'd0);
    ch[1] = 32'hBBBB0002;
    send(1);
    ch[2] = 32'hCCCC0003;
    send(2);
`endif
    drain();

    send(3);
    chk("bad_sel_data", out_data, 32'd0);
    chk("bad_sel_err", 32'(sel_err), 32'd1);
    send(1);
    drain();
    chk("err_sticky", 32'(sel_err), 32'd1);

    out_ready = 0;
    send(0);
`ifdef NWAY_MUX_SKID_EN
    send(1);
`endif
    in_valid = 0;
    pulse_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_xfer", 32'(xfer_count), 32'd0);
    chk("mid_rst_err", 32'(sel_err), 32'd0);

    begin
      int n = 0, guard = 0;
      bit acc;
      rnd_run = 1;
      while (n < 1000 && guard < 20000) begin
        if (!in_valid && $urandom % 2 == 1) begin
          in_valid = 1;
          for (int i = 0; i < N; i++) ch[i] = $urandom;
          sel = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) n++;
        @(posedge clk);
        #1;
        if (acc) in_valid = 0;
        guard++;
      end
      rnd_run = 0;
      #1;
      chk("random_words_sent", 32'(n), 32'd1000);
    end
    drain();

    pulse_reset();
    out_ready = 1;
    in_valid = 1;
    sel = 0;
    begin
      int g = 0;
      while (xfer_count != 16'hFFFF && g < 70000) begin
        @(negedge clk);
        g++;
      end
      chk("cnt_ffff", 32'(xfer_count), 32'h0000FFFF);
      g = 0;
      while (!(out_valid && out_ready) && g < 100) begin
        @(negedge clk);
        g++;
      end
      @(posedge clk);
      #1;
      chk("cnt_wrap", 32'(xfer_count), 32'd0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
